// File: rtl/bus_ctrl.sv
// CPU-side bus controller: registers one CPU request, drives the enabled address
// decoder, waits on the selected slave with a timeout, and returns a one-cycle completion.
module bus_ctrl #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 32,
   parameter int SEL_SIZE = 4,
   parameter logic [(1<<SEL_SIZE)-1:0] MAP_MASK = '1,
   parameter int TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cpu_req,
   input  logic                  cpu_we,
   input  logic [ADDR_WIDTH-1:0] cpu_addr,
   input  logic [DATA_WIDTH-1:0] cpu_wdata,
   output logic                  cpu_ready,
   output logic                  cpu_err,
   output logic [DATA_WIDTH-1:0] cpu_rdata,
   output logic                  dec_en,
   output logic [SEL_SIZE-1:0]   dec_addr,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic                  bus_we,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_wait,
   input  logic [DATA_WIDTH-1:0] bus_rdata
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   state_t                state, state_nx;
   logic [CW-1:0]         cnt, cnt_nx;
   logic                  ready_nx, err_nx, den_nx, bwe_nx;
   logic [DATA_WIDTH-1:0] rdata_nx, bwdata_nx;
   logic [SEL_SIZE-1:0]   daddr_nx;
   logic [ADDR_WIDTH-1:0] baddr_nx;
   logic [SEL_SIZE-1:0]   region;

   assign region = cpu_addr[ADDR_WIDTH-1 -: SEL_SIZE];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         cnt       <= '0;
         cpu_ready <= 1'b0;
         cpu_err   <= 1'b0;
         cpu_rdata <= '0;
         dec_en    <= 1'b0;
         dec_addr  <= '0;
         bus_addr  <= '0;
         bus_we    <= 1'b0;
         bus_wdata <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         cpu_ready <= ready_nx;
         cpu_err   <= err_nx;
         cpu_rdata <= rdata_nx;
         dec_en    <= den_nx;
         dec_addr  <= daddr_nx;
         bus_addr  <= baddr_nx;
         bus_we    <= bwe_nx;
         bus_wdata <= bwdata_nx;
      end
   end

   // Every output is computed one cycle ahead so the registered copy lines up with the state.
   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      ready_nx  = 1'b0;
      err_nx    = cpu_err;
      rdata_nx  = cpu_rdata;
      den_nx    = dec_en;
      daddr_nx  = dec_addr;
      baddr_nx  = bus_addr;
      bwe_nx    = bus_we;
      bwdata_nx = bus_wdata;
      case (state)
         IDLE: begin
            if (cpu_req) begin
               daddr_nx  = region;
               baddr_nx  = cpu_addr;
               bwe_nx    = cpu_we;
               bwdata_nx = cpu_wdata;
               if (MAP_MASK[region]) begin
                  state_nx = ACCESS;
                  den_nx   = 1'b1;
                  cnt_nx   = '0;
               end else begin
                  state_nx = DONE;
                  ready_nx = 1'b1;
                  err_nx   = 1'b1;
                  rdata_nx = '1;
                  den_nx   = 1'b0;
               end
            end
         end
         ACCESS: begin
            if (!bus_wait) begin
               state_nx = DONE;
               ready_nx = 1'b1;
               err_nx   = 1'b0;
               rdata_nx = bus_rdata;
               den_nx   = 1'b0;
            end else if (cnt == TMAX) begin
               state_nx = DONE;
               ready_nx = 1'b1;
               err_nx   = 1'b1;
               rdata_nx = '1;
               den_nx   = 1'b0;
            end else begin
               cnt_nx = cnt + CW'(1);
            end
         end
         DONE: begin
            state_nx = IDLE;
            den_nx   = 1'b0;
         end
         default: begin
            state_nx = IDLE;
            den_nx   = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_bus_ctrl.sv
// Directed bench for bus_ctrl: expected completions are queued when a request is
// driven and compared when cpu_ready appears.
module tb_bus_ctrl;

   localparam int AW = 16;
   localparam int DW = 32;
   localparam int SS = 4;
   localparam int TO = 15;
   localparam logic [15:0] MASK = 16'h00FF;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cpu_req, cpu_we;
   logic [AW-1:0] cpu_addr;
   logic [DW-1:0] cpu_wdata;
   logic          cpu_ready, cpu_err;
   logic [DW-1:0] cpu_rdata;
   logic          dec_en;
   logic [SS-1:0] dec_addr;
   logic [AW-1:0] bus_addr;
   logic          bus_we;
   logic [DW-1:0] bus_wdata;
   logic          bus_wait;
   logic [DW-1:0] bus_rdata;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      int            k;
      logic          err;
      logic [DW-1:0] rdata;
      int            lat;
      int            den;
   } exp_t;

   exp_t sb[$];

   bus_ctrl #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .SEL_SIZE(SS),
      .MAP_MASK(MASK),
      .TIMEOUT(TO)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .cpu_req(cpu_req),
      .cpu_we(cpu_we),
      .cpu_addr(cpu_addr),
      .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready),
      .cpu_err(cpu_err),
      .cpu_rdata(cpu_rdata),
      .dec_en(dec_en),
      .dec_addr(dec_addr),
      .bus_addr(bus_addr),
      .bus_we(bus_we),
      .bus_wdata(bus_wdata),
      .bus_wait(bus_wait),
      .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference model: latency counted in observed cycles from the edge that samples cpu_req.
   function automatic void pushExp(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                   input int k, input int start, input logic [DW-1:0] rd);
      exp_t e;
      logic [SS-1:0] r;
      r = addr[AW-1 -: SS];
      e.we = we;
      e.addr = addr;
      e.wdata = wdata;
      e.k = k;
      if (!MASK[r]) begin
         e.err = 1'b1; e.rdata = '1; e.lat = start + 1; e.den = 0;
      end else if (k >= TO) begin
         e.err = 1'b1; e.rdata = '1; e.lat = start + 2 + TO; e.den = TO + 1;
      end else begin
         e.err = 1'b0; e.rdata = rd; e.lat = start + 2 + k; e.den = k + 1;
      end
      sb.push_back(e);
   endfunction

   task automatic applyStimulus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int k);
      cpu_req = 1'b1;
      cpu_we = we;
      cpu_addr = addr;
      cpu_wdata = wdata;
      pushExp(we, addr, wdata, k, 0, bus_rdata);
   endtask

   // Runs the bus side until every queued completion has been seen or the budget expires.
   task automatic observe(input int budget, input logic hold, input logic [AW-1:0] addr2, input logic [DW-1:0] wdata2);
      int cyc = 0;
      int den = 0;
      int acc = 0;
      exp_t e;
      while (sb.size() > 0 && cyc < budget) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            if (hold) begin
               cpu_addr = addr2;
               cpu_wdata = wdata2;
               pushExp(cpu_we, addr2, wdata2, 0, 3, bus_rdata);
            end else begin
               cpu_req = 1'b0;
            end
         end
         if (dec_en) begin
            if (den == 0) begin
               checkOutput("bus_addr", 64'(bus_addr), 64'(sb[0].addr));
               checkOutput("dec_addr", 64'(dec_addr), 64'(sb[0].addr[AW-1 -: SS]));
               checkOutput("bus_we", 64'(bus_we), 64'(sb[0].we));
               checkOutput("bus_wdata", 64'(bus_wdata), 64'(sb[0].wdata));
            end
            den++;
            bus_wait = (acc < sb[0].k);
            acc++;
         end else begin
            bus_wait = 1'b0;
         end
         if (cpu_ready) begin
            e = sb.pop_front();
            checkOutput("cpu_err", 64'(cpu_err), 64'(e.err));
            checkOutput("cpu_rdata", 64'(cpu_rdata), 64'(e.rdata));
            checkOutput("latency", 64'(cyc), 64'(e.lat));
            checkOutput("dec_en_cycles", 64'(den), 64'(e.den));
            den = 0;
            acc = 0;
            if (sb.size() == 0) cpu_req = 1'b0;
         end
      end
      if (sb.size() > 0) begin
         checkOutput("completion_budget", 64'(sb.size()), 64'd0);
         sb.delete();
         cpu_req = 1'b0;
      end
      repeat (3) begin
         @(posedge clk); #1;
         checkOutput("quiet_ready", 64'(cpu_ready), 64'd0);
         checkOutput("quiet_dec_en", 64'(dec_en), 64'd0);
      end
   endtask

   initial begin
      reset_n = 1'b0;
      cpu_req = 1'b0;
      cpu_we = 1'b0;
      cpu_addr = '0;
      cpu_wdata = '0;
      bus_wait = 1'b0;
      bus_rdata = '0;
      #2;
      checkOutput("rst_cpu_ready", 64'(cpu_ready), 64'd0);
      checkOutput("rst_cpu_err", 64'(cpu_err), 64'd0);
      checkOutput("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
      checkOutput("rst_dec_en", 64'(dec_en), 64'd0);
      checkOutput("rst_dec_addr", 64'(dec_addr), 64'd0);
      checkOutput("rst_bus_addr", 64'(bus_addr), 64'd0);
      checkOutput("rst_bus_we", 64'(bus_we), 64'd0);
      checkOutput("rst_bus_wdata", 64'(bus_wdata), 64'd0);
      #10;
      reset_n = 1'b1;
      @(posedge clk); #1;

      $display("[TB] write region 3, no wait");
      bus_rdata = 32'hCAFE0001;
      applyStimulus(1'b1, 16'h3004, 32'hDEADBEEF, 0);
      observe(40, 1'b0, '0, '0);

      $display("[TB] read region 5, three wait cycles");
      bus_rdata = 32'h12345678;
      applyStimulus(1'b0, 16'h5000, 32'h0, 3);
      observe(40, 1'b0, '0, '0);

      $display("[TB] read region 1, slave never answers");
      bus_rdata = 32'h0000AAAA;
      applyStimulus(1'b0, 16'h1234, 32'h0, 1000);
      observe(40, 1'b0, '0, '0);

      $display("[TB] read unmapped region 10");
      applyStimulus(1'b0, 16'hA000, 32'h0, 0);
      observe(40, 1'b0, '0, '0);

      $display("[TB] back-to-back reads with cpu_req held");
      bus_rdata = 32'h0BADF00D;
      applyStimulus(1'b0, 16'h2010, 32'h0, 0);
      observe(40, 1'b1, 16'h7020, 32'h0);

      $display("[TB] reset pulse in the middle of an access");
      cpu_req = 1'b1;
      cpu_we = 1'b0;
      cpu_addr = 16'h2100;
      bus_wait = 1'b1;
      @(posedge clk); #1;
      cpu_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("pre_reset_dec_en", 64'(dec_en), 64'd1);
      #1 reset_n = 1'b0;
      #1;
      checkOutput("async_reset_dec_en", 64'(dec_en), 64'd0);
      checkOutput("async_reset_bus_addr", 64'(bus_addr), 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      bus_wait = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         checkOutput("aborted_no_ready", 64'(cpu_ready), 64'd0);
      end
      bus_rdata = 32'h55AA33CC;
      applyStimulus(1'b0, 16'h4008, 32'h0, 1);
      observe(40, 1'b0, '0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_ctrl.md
# bus_ctrl

CPU-side bus controller that sits directly upstream of the enabled address decoder. It accepts one CPU request at a time and registers the address, write data and direction. It drives the region number and enable into the decoder, waits for the selected slave (with a timeout), then returns read data and a one-cycle ready/error completion to the CPU. Unmapped regions are rejected without ever enabling the decoder.

## Interface

Parameters:
- ADDR_WIDTH, 16: CPU address width.
- DATA_WIDTH, 32: data bus width.
- SEL_SIZE, 4: number of top address bits forwarded to the decoder; gives 1<<SEL_SIZE regions.
- MAP_MASK, all ones (width 1<<SEL_SIZE): bit r=1 means region r is populated.
- TIMEOUT, 15: maximum ACCESS cycles with bus_wait high before an error completion; range 1..255.

Ports:
- clk  in  1  single system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_req  in  1  request; sampled only in IDLE.
- cpu_we  in  1  1=write, 0=read; sampled with cpu_req.
- cpu_addr  in  ADDR_WIDTH  byte/word address; sampled with cpu_req.
- cpu_wdata  in  DATA_WIDTH  write data; sampled with cpu_req.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_err  out  1  valid with cpu_ready; 1 = timeout or unmapped region.
- cpu_rdata  out  DATA_WIDTH  read data; valid with cpu_ready.
- dec_en  out  1  enable into decoder_en.
- dec_addr  out  SEL_SIZE  region number = latched cpu_addr[ADDR_WIDTH-1 -: SEL_SIZE].
- bus_addr  out  ADDR_WIDTH  latched full address to slaves.
- bus_we  out  1  latched direction; qualified by dec_en.
- bus_wdata  out  DATA_WIDTH  latched write data.
- bus_wait  in  1  selected slave stretches the access while high.
- bus_rdata  in  DATA_WIDTH  read data already muxed from the selected slave.

## Operation

- States: IDLE, ACCESS, DONE. All outputs are registered.
- IDLE:
  - cpu_req=1 latches cpu_we, cpu_addr and cpu_wdata.
  - If MAP_MASK[region]=1, go to ACCESS with dec_en=1 and the wait counter cleared.
  - If MAP_MASK[region]=0, go directly to DONE with cpu_err=1 and cpu_rdata all ones. dec_en is never asserted.
- ACCESS:
  - dec_en=1 and the bus_* outputs are held stable for the whole state.
  - Each cycle, bus_wait is sampled:
    - bus_wait=0: capture bus_rdata into cpu_rdata (writes also capture it; the value is don't-care for the CPU) and go to DONE with cpu_err=0.
    - bus_wait=1: increment the counter. When the counter reaches TIMEOUT, go to DONE with cpu_err=1 and cpu_rdata all ones.
- DONE:
  - cpu_ready=1 for exactly one cycle; dec_en=0.
  - Unconditionally return to IDLE.
  - cpu_req is ignored in DONE.
- cpu_rdata and cpu_err hold their values until the next completion.
- Wait counter width is clog2(TIMEOUT+1); it saturates and never wraps.
- Reset (asynchronous, any state, including mid-ACCESS):
  - State returns to IDLE immediately.
  - cpu_ready, cpu_err and dec_en go to 0; cpu_rdata, dec_addr, bus_addr and bus_wdata go to 0; bus_we goes to 0.
  - The aborted transaction produces no completion.

## Timing

- Request sampled at edge N (IDLE) → dec_en high from N+1.
- bus_wait=0 at edge N+1 → cpu_ready high during cycle N+2. Minimum latency is 2 cycles from req to ready.
- k wait cycles (k < TIMEOUT) add k cycles: ready in cycle N+2+k.
- Timeout: ready with error in cycle N+2+TIMEOUT. dec_en is high for exactly TIMEOUT+1 cycles.
- Unmapped region: ready with error in cycle N+1; dec_en is never high.
- Back-to-back: if cpu_req is still high in the IDLE cycle after DONE, a new transaction starts. Peak throughput is one transaction per 3 cycles.
- cpu_req high during ACCESS or DONE has no effect; the latched values do not change.

## Test plan

- Reset with reset_n=0 → all outputs 0. Release reset, write addr 0x3004, data 0xDEADBEEF, bus_wait=0 → dec_addr=3, dec_en high for 1 cycle, bus_we=1, cpu_ready in cycle N+2, cpu_err=0.
- Read from region 5 with bus_wait high for 3 cycles and bus_rdata=0x12345678 → cpu_ready in cycle N+5, cpu_rdata=0x12345678, cpu_err=0.
- bus_wait held high, TIMEOUT=15 → dec_en high for 16 cycles, then cpu_ready=1, cpu_err=1, cpu_rdata=0xFFFFFFFF.
- MAP_MASK=16'h00FF, read addr 0xA000 → dec_en never high, cpu_ready in cycle N+1 with cpu_err=1.
- cpu_req held high continuously for two reads → exactly one cpu_ready per 3 cycles; second read uses the new cpu_addr sampled in IDLE.
- reset_n pulsed low mid-ACCESS → dec_en drops without waiting for a clock edge, no cpu_ready is produced, and the next request behaves normally.
